riscv_mmio_timer: RTL and testbench

Memory-mapped machine timer that responds on the core's data port, alongside the data RAM. The core is the initiator; this block decodes the load/store address, byte enables and write strobe, and returns read data. It keeps a 64-bit free-running mtime counter and a 64-bit mtimecmp compare register. It raises a level timer interrupt toward the CSR/trap logic.

---
 rtl/riscv_mmio_timer.sv | 208 ++++++++++++++++++++
 tb/tb_riscv_mmio_timer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mmio_timer.sv
// ---------------------------------------------------------------------------
// riscv_mmio_timer
//
// Machine timer on the core's data port. Holds a 64-bit free-running mtime
// counter (advanced by a prescaled tick) and a 64-bit mtimecmp register.
// A sticky PEND bit latches whenever mtime >= mtimecmp and drives the level
// timer interrupt when IRQ_EN is set.
//
// Register map (word offset from BASE_ADDR):
//   0x00 MTIME_LO     RW
//   0x04 MTIME_HI     RW
//   0x08 MTIMECMP_LO  RW
//   0x0C MTIMECMP_HI  RW
//   0x10 CTRL         RW   bit0 EN, bit1 IRQ_EN
//   0x14 STATUS       W1C  bit0 PEND
//   0x18, 0x1C        read 0, writes ignored
//
// Bus handshake: there is no valid/ready pair. Every cycle is a transfer:
// a store is accepted on the rising edge whenever write_en & sel, and a
// load is answered combinationally in the same cycle with zero wait states.
//
// Ports:
//   clk        system clock, rising edge
//   x_reset    asynchronous active-low reset
//   addr       data-port byte address
//   write_en   store strobe
//   wdata      lane-aligned store data
//   wbe        byte enables, bit n gates wdata[8n+7:8n]
//   sel        address hits this block
//   rdata      combinational read data, 0 when not selected
//   timer_irq  level interrupt, PEND & IRQ_EN
// ---------------------------------------------------------------------------
module riscv_mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic [31:0] addr,
    input  logic        write_en,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        timer_irq
);

    localparam logic [2:0]  OFF_MTIME_LO = 3'd0;
    localparam logic [2:0]  OFF_MTIME_HI = 3'd1;
    localparam logic [2:0]  OFF_CMP_LO   = 3'd2;
    localparam logic [2:0]  OFF_CMP_HI   = 3'd3;
    localparam logic [2:0]  OFF_CTRL     = 3'd4;
    localparam logic [2:0]  OFF_STATUS   = 3'd5;
    localparam logic [15:0] PCNT_LAST    = 16'(PRESCALE - 1);

    // Replace only the enabled byte lanes of a 32-bit register.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Register state
    logic [31:0] mtime_lo;
    logic [31:0] mtime_hi;
    logic [31:0] cmp_lo;
    logic [31:0] cmp_hi;
    logic        ctrl_en;
    logic        ctrl_irq_en;
    logic        pend;
    logic [15:0] pcnt;

    // Decode and strobes
    logic [2:0]  offset;
    logic        wr;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        clr_pend;
    logic        tick;
    logic        match;
    logic [63:0] mtime_inc;
    logic [31:0] mtime_lo_next;
    logic [31:0] mtime_hi_next;

    // addr[1:0] does not take part in word decode.
    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[1:0]};

    assign sel    = (addr[31:5] == BASE_ADDR[31:5]);
    assign offset = addr[4:2];
    assign wr     = write_en & sel;

    assign wr_mtime_lo = wr & (offset == OFF_MTIME_LO);
    assign wr_mtime_hi = wr & (offset == OFF_MTIME_HI);
    assign wr_cmp_lo   = wr & (offset == OFF_CMP_LO);
    assign wr_cmp_hi   = wr & (offset == OFF_CMP_HI);
    assign wr_ctrl     = wr & (offset == OFF_CTRL) & wbe[0];
    // PEND lives in byte 0, so the clear needs that lane enabled.
    assign clr_pend    = wr & (offset == OFF_STATUS) & wbe[0] & wdata[0];

    assign tick      = ctrl_en & (pcnt == PCNT_LAST);
    assign match     = ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
    assign mtime_inc = {mtime_hi, mtime_lo} + 64'd1;

    // A store to either mtime half wins over a tick in the same cycle: the
    // written half takes the new bytes, the other half holds, and that
    // cycle's increment is dropped.
    always_comb begin
        mtime_lo_next = mtime_lo;
        mtime_hi_next = mtime_hi;
        if (wr_mtime_lo) begin
            mtime_lo_next = merge_bytes(mtime_lo, wdata, wbe);
        end else if (wr_mtime_hi) begin
            mtime_hi_next = merge_bytes(mtime_hi, wdata, wbe);
        end else if (tick) begin
            mtime_lo_next = mtime_inc[31:0];
            mtime_hi_next = mtime_inc[63:32];
        end
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            mtime_lo <= 32'h0;
            mtime_hi <= 32'h0;
        end else begin
            mtime_lo <= mtime_lo_next;
            mtime_hi <= mtime_hi_next;
        end
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            cmp_lo <= 32'hFFFF_FFFF;
            cmp_hi <= 32'hFFFF_FFFF;
        end else begin
            if (wr_cmp_lo) begin
                cmp_lo <= merge_bytes(cmp_lo, wdata, wbe);
            end
            if (wr_cmp_hi) begin
                cmp_hi <= merge_bytes(cmp_hi, wdata, wbe);
            end
        end
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en     <= wdata[0];
            ctrl_irq_en <= wdata[1];
        end
    end

    // Prescaler counts only while enabled and holds its partial count when
    // disabled, so a pause does not lose or gain a fraction of a tick.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            pcnt <= 16'h0;
        end else if (ctrl_en) begin
            if (tick) begin
                pcnt <= 16'h0;
            end else begin
                pcnt <= pcnt + 16'h1;
            end
        end
    end

    // Set has priority over the software clear: a still-true match keeps
    // PEND asserted, so software must raise mtimecmp before clearing.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            pend <= 1'b0;
        end else if (match) begin
            pend <= 1'b1;
        end else if (clr_pend) begin
            pend <= 1'b0;
        end
    end

    assign timer_irq = pend & ctrl_irq_en;

    always_comb begin
        rdata = 32'h0;
        if (sel) begin
            case (offset)
                OFF_MTIME_LO: rdata = mtime_lo;
                OFF_MTIME_HI: rdata = mtime_hi;
                OFF_CMP_LO:   rdata = cmp_lo;
                OFF_CMP_HI:   rdata = cmp_hi;
                OFF_CTRL:     rdata = {30'h0, ctrl_irq_en, ctrl_en};
                OFF_STATUS:   rdata = {31'h0, pend};
                default:      rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mmio_timer.sv
module tb_riscv_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int P_A = 4;
  localparam int P_B = 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        x_reset;
  logic [31:0] addr;
  logic        write_en;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        sel_a, sel_b;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  riscv_mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(P_A)) dut_a (
    .clk(clk), .x_reset(x_reset), .addr(addr), .write_en(write_en),
    .wdata(wdata), .wbe(wbe), .sel(sel_a), .rdata(rdata_a), .timer_irq(irq_a)
  );

  riscv_mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(P_B)) dut_b (
    .clk(clk), .x_reset(x_reset), .addr(addr), .write_en(write_en),
    .wdata(wdata), .wbe(wbe), .sel(sel_b), .rdata(rdata_b), .timer_irq(irq_b)
  );

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_b. Ticks are derived from the
  // total number of enabled cycles since reset.
  logic [63:0] m_mtime[2];
  logic [63:0] m_cmp[2];
  bit          m_en[2];
  bit          m_ie[2];
  bit          m_pend[2];
  int unsigned m_encyc[2];

  function automatic bit hit(input logic [31:0] a);
    return (a & 32'hFFFF_FFE0) == BASE;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [31:0] a);
    if (!hit(a)) return 32'h0;
    case (a[4:2])
      3'd0: return m_mtime[i][31:0];
      3'd1: return m_mtime[i][63:32];
      3'd2: return m_cmp[i][31:0];
      3'd3: return m_cmp[i][63:32];
      3'd4: return {30'h0, m_ie[i], m_en[i]};
      3'd5: return {31'h0, m_pend[i]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge x_reset) begin
    logic [63:0] nt;
    bit tk, mt, clr;
    if (!x_reset) begin
      for (int i = 0; i < 2; i++) begin
        m_mtime[i] = 64'h0; m_cmp[i] = '1; m_en[i] = 0; m_ie[i] = 0;
        m_pend[i] = 0; m_encyc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mt = (m_mtime[i] >= m_cmp[i]);
        tk = 0;
        if (m_en[i]) begin
          m_encyc[i] = m_encyc[i] + 1;
          tk = (m_encyc[i] % ((i == 0) ? P_A : P_B)) == 0;
        end
        nt = tk ? m_mtime[i] + 64'd1 : m_mtime[i];
        clr = 0;
        if (write_en && hit(addr)) begin
          case (addr[4:2])
            3'd0: nt = {m_mtime[i][63:32], lanes(m_mtime[i][31:0], wdata, wbe)};
            3'd1: nt = {lanes(m_mtime[i][63:32], wdata, wbe), m_mtime[i][31:0]};
            3'd2: m_cmp[i][31:0] = lanes(m_cmp[i][31:0], wdata, wbe);
            3'd3: m_cmp[i][63:32] = lanes(m_cmp[i][63:32], wdata, wbe);
            3'd4: if (wbe[0]) begin m_en[i] = wdata[0]; m_ie[i] = wdata[1]; end
            3'd5: clr = wbe[0] & wdata[0];
            default: ;
          endcase
        end
        m_mtime[i] = nt;
        m_pend[i] = mt | (m_pend[i] & !clr);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; wdata = d; wbe = be; write_en = 1'b1;
    @(posedge clk);
    #1 write_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare both DUTs' read data, select and interrupt with the model.
  task automatic check_read(input logic [31:0] a, input string tag);
    @(negedge clk);
    addr = a; write_en = 1'b0;
    #1;
    check({tag, "_rd_a"}, rdata_a, model_read(0, a));
    check({tag, "_rd_b"}, rdata_b, model_read(1, a));
    check({tag, "_sel_a"}, sel_a, hit(a));
    check({tag, "_sel_b"}, sel_b, hit(a));
    check({tag, "_irq_a"}, irq_a, m_pend[0] & m_ie[0]);
    check({tag, "_irq_b"}, irq_b, m_pend[1] & m_ie[1]);
  endtask

  // which: 0 = dut_a only, 1 = dut_b only, 2 = both
  task automatic expect_const(input int which, input logic [31:0] a,
                              input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = a; write_en = 1'b0;
    #1;
    if (which != 1) check({tag, "_a"}, rdata_a, exp);
    if (which != 0) check({tag, "_b"}, rdata_b, exp);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 8; k++) check_read(BASE + 32'(k * 4), tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    x_reset = 1'b0; write_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    x_reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d;
    int op;
    x_reset = 1'b0; addr = BASE; write_en = 1'b0; wdata = 32'h0; wbe = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    x_reset = 1'b1;

    // Reset values
    expect_const(2, BASE + 32'h00, 32'h0, "rst_mtime_lo");
    expect_const(2, BASE + 32'h04, 32'h0, "rst_mtime_hi");
    expect_const(2, BASE + 32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    expect_const(2, BASE + 32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    expect_const(2, BASE + 32'h10, 32'h0, "rst_ctrl");
    expect_const(2, BASE + 32'h14, 32'h0, "rst_status");
    check("rst_irq_a", irq_a, 1'b0);
    check("rst_irq_b", irq_b, 1'b0);

    // Counting with PRESCALE = 4 on dut_a
    bus_write(BASE + 32'h10, 32'h1, 4'hF);
    cycles(4);
    expect_const(0, BASE, 32'd1, "cnt_after_4");
    check_read(BASE, "cnt4");
    cycles(95);
    expect_const(0, BASE, 32'd25, "cnt_after_100");
    bus_write(BASE + 32'h10, 32'h0, 4'hF);
    cycles(50);
    expect_const(0, BASE, 32'd25, "cnt_frozen");
    check_all("frozen");

    // Asynchronous reset mid-count
    bus_write(BASE, 32'd5, 4'hF);
    bus_write(BASE + 32'h10, 32'h1, 4'hF);
    expect_const(2, BASE, 32'd5, "pre_rst_mtime");
    #1 x_reset = 1'b0;
    #1 check("async_rst_mtime_a", rdata_a, 32'h0);
    check("async_rst_mtime_b", rdata_b, 32'h0);
    addr = BASE + 32'h10;
    #1 check("async_rst_ctrl_a", rdata_a, 32'h0);
    check("async_rst_ctrl_b", rdata_b, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    x_reset = 1'b1;

    // Carry from LO to HI, then 64-bit wrap (dut_b ticks every cycle)
    bus_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(BASE + 32'h04, 32'h0, 4'hF);
    bus_write(BASE + 32'h10, 32'h1, 4'hF);
    cycles(1);
    expect_const(1, BASE + 32'h00, 32'h0, "carry_lo");
    expect_const(1, BASE + 32'h04, 32'h1, "carry_hi");
    check_all("carry");
    bus_write(BASE + 32'h10, 32'h0, 4'hF);
    bus_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
    bus_write(BASE + 32'h10, 32'h1, 4'hF);
    cycles(1);
    expect_const(1, BASE + 32'h00, 32'h0, "wrap_lo");
    expect_const(1, BASE + 32'h04, 32'h0, "wrap_hi");
    check_all("wrap");

    // Byte lanes
    do_reset();
    bus_write(BASE + 32'h08, 32'hAABB_CCDD, 4'b0100);
    expect_const(2, BASE + 32'h08, 32'hFFBB_FFFF, "lane_cmp_lo");
    expect_const(2, BASE + 32'h0C, 32'hFFFF_FFFF, "lane_cmp_hi");

    // Interrupt
    do_reset();
    bus_write(BASE + 32'h08, 32'd10, 4'hF);
    bus_write(BASE + 32'h0C, 32'd0, 4'hF);
    bus_write(BASE + 32'h10, 32'h3, 4'hF);
    cycles(11);
    check("irq_b_set", irq_b, 1'b1);
    for (int k = 0; k < 50; k++) check_read(BASE + 32'h14, "irq_run");
    check("irq_a_set", irq_a, 1'b1);
    bus_write(BASE + 32'h14, 32'h1, 4'h1);
    expect_const(2, BASE + 32'h14, 32'h1, "w1c_match_holds");
    check_read(BASE + 32'h14, "w1c_hold");
    bus_write(BASE + 32'h0C, 32'h1, 4'hF);
    bus_write(BASE + 32'h14, 32'h1, 4'h1);
    expect_const(2, BASE + 32'h14, 32'h0, "w1c_cleared");
    check("irq_a_clr", irq_a, 1'b0);
    check("irq_b_clr", irq_b, 1'b0);

    // Decode miss and write collision
    expect_const(2, BASE + 32'h20, 32'h0, "miss_rdata");
    check("miss_sel_a", sel_a, 1'b0);
    check("miss_sel_b", sel_b, 1'b0);
    bus_write(BASE + 32'h20, 32'h1234_5678, 4'hF);
    bus_write(BASE + 32'h30, 32'h0, 4'hF);
    expect_const(2, BASE + 32'h10, 32'h3, "miss_ctrl_kept");
    check_all("miss");
    bus_write(BASE + 32'h00, 32'h100, 4'hF);
    expect_const(1, BASE + 32'h00, 32'h100, "collision_lo");
    check_all("collision");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 19);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
      if (op < 7) bus_write(a, d, 4'($urandom_range(0, 15)));
      else if (op < 13) check_read(a, "rnd");
      else if (op < 16) cycles($urandom_range(1, 20));
      else if (op < 19) bus_write(BASE + 32'h10, 32'($urandom_range(0, 3)), 4'hF);
      else do_reset();
    end
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
